ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single-port byte-addressed PhysicalRAM between the instruction-fetch port (read-only) and the data port (read/write). Each accepted request becomes one RAM access, and the result comes back as a one-cycle response pulse. The block holds off all grants until the RAM file preload window has passed, then arbitrates round-robin. It sits between the CPU front end/load-store unit and PhysicalRAM, and is the only driver of the RAM's address, WriteEnable and WriteValue inputs.

## Interface
- ADDR_LIMIT, 65536: RAM size in bytes. A valid word address satisfies addr <= ADDR_LIMIT-4.
- INIT_CYCLES, 4: cycles after reset release before the first grant. Must be ≥2 to cover the RAM preload edge.
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address
- if_req_ready  out  1  fetch request accepted when valid&ready
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_data  out  32  fetch read data
- if_rsp_error  out  1  address out of range
- d_req_valid  in  1  data request
- d_req_write  in  1  1=write, 0=read
- d_req_addr  in  32  data byte address
- d_req_wdata  in  32  write data
- d_req_ready  out  1  data request accepted
- d_rsp_valid  out  1  one-cycle data response (read data or write ack)
- d_rsp_data  out  32  data read data; 0 for writes and errors
- d_rsp_error  out  1  address out of range
- ram_address  out  32  to RAM address
- ram_write_enable  out  1  to RAM WriteEnable
- ram_write_value  out  32  to RAM WriteValue
- ram_read_value  in  32  from RAM ReadValue (registered in RAM, 1-cycle latency)

## Operation
- Reset values: all outputs 0, state INIT, init counter = INIT_CYCLES, last_grant = IF (so data wins the first tie).
- FSM states:
  - INIT: decrement the counter each cycle. At 0, go to IDLE.
  - IDLE: ready is driven combinationally, and only to the arbitration winner.
    - Only one port valid: that port wins.
    - Both valid: the port ≠ last_grant wins.
    - On handshake: latch port, write flag (IF is always read), addr, wdata; set error = addr > ADDR_LIMIT-4; update last_grant; go to ACCESS.
  - ACCESS:
    - No error: drive ram_address, ram_write_value, and ram_write_enable = write flag.
    - Error: ram_write_enable stays 0.
    - Go to CAPTURE.
  - CAPTURE:
    - ram_write_enable returns to 0.
    - Register rsp_data = ram_read_value (read, no error), else 0.
    - Set the latched port's rsp_valid = 1 and rsp_error = error flag.
    - Go to IDLE.
- rsp_valid is high exactly one cycle. There is no response backpressure; requesters must always accept.
- ram_write_enable is 1 only in ACCESS cycles of error-free writes.
- Requesters must not make valid depend on ready. Request fields must be held stable while valid & !ready.
- Asynchronous reset mid-access: outputs clear immediately and ram_write_enable drops before the next edge, so no write commits. The in-flight request is dropped with no response.

## Timing
- Handshake in cycle T (IDLE). RAM inputs are driven in T+1 (ACCESS). Write commits, or read data registers in RAM, at the T+1 edge.
- rsp_valid is high in cycle T+3 for both reads and writes. IDLE is re-entered in T+3, so the next handshake can occur in T+3: throughput is 1 request per 3 cycles.
- The first handshake after reset release is possible in cycle INIT_CYCLES+1.
- Ready is never asserted outside IDLE.

## Structure
- Package ram_arb_pkg holds:
  - state enum {INIT, IDLE, ACCESS, CAPTURE}
  - port enum {PORT_IF, PORT_D}
  - word-size constant 4
- One sub-module, ram_rr_pick: a combinational 2-way round-robin picker (valids, last_grant → grant one-hot).

## Test plan
- Reset release, if_req_valid held from cycle 0 at addr 0x0 → if_req_ready stays 0 until cycle INIT_CYCLES+1. if_rsp_data then equals preloaded bytes 0..3, little-endian.
- Data write 0xDEADBEEF to 0x100, then fetch 0x100 → d_rsp_valid pulses 3 cycles after the write handshake with data 0. if_rsp_data = 0xDEADBEEF.
- Both ports valid continuously → grants alternate D, IF, D, IF…, each response 3 cycles after its handshake.
- Data write to 0xFFFD → d_rsp_error=1, ram_write_enable never asserted, contents of 0xFFFC..0xFFFF unchanged on readback.
- Reset asserted during ACCESS of a write to 0x200 → no response pulse, and a readback of 0x200 after re-init returns the old value.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the PhysicalRAM port arbiter.
package ram_arb_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACCESS,
    CAPTURE
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // Request context carried from the handshake to the response. The address
  // and write data go straight into the RAM-facing registers, so they are not
  // kept here.
  typedef struct packed {
    port_e port;
    logic  write;
    logic  err;
  } req_t;

  // A word access is legal when all four bytes fall inside the RAM.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned limit);
    return addr > 32'(limit - WORD_BYTES);
  endfunction

endpackage

// File: rtl/ram_rr_pick.sv
// Two-way round-robin picker: one-hot grant among valid requesters, with the
// requester that was not served last winning a tie.
module ram_rr_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,       // [0] = fetch, [1] = data
  input  port_e      last_grant,
  output logic [1:0] grant
);

  // Lone requester wins; on a tie the port other than last_grant wins.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == PORT_IF) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares single-port PhysicalRAM between the fetch port and the data port.
// One accepted request becomes one RAM access; its result returns three
// cycles after the handshake as a one-cycle response pulse.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT  = 65536,
  parameter int unsigned INIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_error,

  input  logic        d_req_valid,
  input  logic        d_req_write,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_error,

  output logic [31:0] ram_address,
  output logic        ram_write_enable,
  output logic [31:0] ram_write_value,
  input  logic [31:0] ram_read_value
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  state_e            state;
  logic [CNT_W-1:0]  init_cnt;
  port_e             last_grant;
  req_t              req;

  logic [1:0]        grant;
  logic              hs;
  logic              sel_d;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_write;
  logic              sel_err;

  ram_rr_pick u_pick (
    .valid      ({d_req_valid, if_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready only in IDLE and only to the picker's winner; grant is already
  // qualified by valid, so ready alone marks the handshake.
  always_comb begin
    if_req_ready = (state == IDLE) && grant[0];
    d_req_ready  = (state == IDLE) && grant[1];
    hs           = if_req_ready || d_req_ready;
    sel_d        = grant[1];
    sel_addr     = sel_d ? d_req_addr : if_req_addr;
    sel_wdata    = sel_d ? d_req_wdata : 32'd0;
    sel_write    = sel_d && d_req_write;   // fetch is always a read
    sel_err      = addr_err(sel_addr, ADDR_LIMIT);
  end

  // Main FSM. RAM-facing outputs are loaded on the handshake edge so they are
  // valid throughout ACCESS; the write enable is a reset-cleared flop, so an
  // asynchronous reset drops it before the next edge and no write commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= INIT;
      init_cnt         <= CNT_W'(INIT_CYCLES);
      last_grant       <= PORT_IF;
      req              <= '0;
      ram_address      <= 32'd0;
      ram_write_enable <= 1'b0;
      ram_write_value  <= 32'd0;
      if_rsp_valid     <= 1'b0;
      if_rsp_data      <= 32'd0;
      if_rsp_error     <= 1'b0;
      d_rsp_valid      <= 1'b0;
      d_rsp_data       <= 32'd0;
      d_rsp_error      <= 1'b0;
    end else begin
      // Response valids are single-cycle pulses.
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;

      case (state)
        INIT: begin
          // Holds off grants until the RAM preload edge has passed.
          if (init_cnt == '0) state    <= IDLE;
          else                init_cnt <= init_cnt - CNT_W'(1);
        end

        IDLE: begin
          if (hs) begin
            req.port         <= sel_d ? PORT_D : PORT_IF;
            req.write        <= sel_write;
            req.err          <= sel_err;
            last_grant       <= sel_d ? PORT_D : PORT_IF;
            // Out-of-range requests still take the slot but never touch RAM.
            ram_address      <= sel_err ? 32'd0 : sel_addr;
            ram_write_value  <= sel_err ? 32'd0 : sel_wdata;
            ram_write_enable <= sel_write && !sel_err;
            state            <= ACCESS;
          end
        end

        ACCESS: begin
          // Write commits / read data registers inside RAM at this edge.
          ram_write_enable <= 1'b0;
          state            <= CAPTURE;
        end

        CAPTURE: begin
          if (req.port == PORT_D) begin
            d_rsp_valid <= 1'b1;
            d_rsp_error <= req.err;
            d_rsp_data  <= (!req.write && !req.err) ? ram_read_value : 32'd0;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_error <= req.err;
            if_rsp_data  <= req.err ? 32'd0 : ram_read_value;
          end
          state <= IDLE;
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural byte-addressed RAM
// (preloaded with mem[i] = i[7:0], registered read, 1-cycle latency).
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_error;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_write, d_req_ready, d_rsp_valid, d_rsp_error;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [31:0] ram_address, ram_write_value, ram_read_value;
  logic        ram_write_enable;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_LIMIT(65536), .INIT_CYCLES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_req_valid     (if_req_valid),
    .if_req_addr      (if_req_addr),
    .if_req_ready     (if_req_ready),
    .if_rsp_valid     (if_rsp_valid),
    .if_rsp_data      (if_rsp_data),
    .if_rsp_error     (if_rsp_error),
    .d_req_valid      (d_req_valid),
    .d_req_write      (d_req_write),
    .d_req_addr       (d_req_addr),
    .d_req_wdata      (d_req_wdata),
    .d_req_ready      (d_req_ready),
    .d_rsp_valid      (d_rsp_valid),
    .d_rsp_data       (d_rsp_data),
    .d_rsp_error      (d_rsp_error),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_write_value  (ram_write_value),
    .ram_read_value   (ram_read_value)
  );

  // RAM model: preloads on its first edge, then write-commit / registered read.
  logic [7:0] mem [0:65535];
  bit         loaded = 1'b0;

  function automatic logic [31:0] rd32(input logic [15:0] a);
    return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i);
      loaded         <= 1'b1;
      ram_read_value <= 32'd0;
    end else begin
      if (ram_write_enable)
        for (int k = 0; k < 4; k++)
          mem[ram_address[15:0] + 16'(k)] <= ram_write_value[8*k +: 8];
      ram_read_value <= rd32(ram_address[15:0]);
    end
  end

  // Cycle index since reset release, write-enable and response pulse counters.
  int cyc = 0, we_cnt = 0, if_rsp_cnt = 0, d_rsp_cnt = 0;
  always @(posedge clk) begin
    cyc <= reset ? cyc + 1 : 0;
    if (ram_write_enable) we_cnt <= we_cnt + 1;
  end
  always @(negedge clk) begin
    if (if_rsp_valid) if_rsp_cnt <= if_rsp_cnt + 1;
    if (d_rsp_valid)  d_rsp_cnt  <= d_rsp_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called in the handshake cycle T; checks the pulse lands exactly in T+3.
  task automatic wait_rsp(input bit is_d, input logic [31:0] exp_data, input bit exp_err,
                          input string tag);
    @(negedge clk); if_req_valid = 1'b0; d_req_valid = 1'b0; #1;
    chk({tag, "_t1_quiet"}, {30'd0, d_rsp_valid, if_rsp_valid}, 32'd0);
    @(negedge clk); #1;
    chk({tag, "_t2_quiet"}, {30'd0, d_rsp_valid, if_rsp_valid}, 32'd0);
    @(negedge clk); #1;
    chk({tag, "_t3_valid"}, {30'd0, d_rsp_valid, if_rsp_valid}, is_d ? 32'd2 : 32'd1);
    chk({tag, "_data"}, is_d ? d_rsp_data : if_rsp_data, exp_data);
    chk({tag, "_err"}, {31'd0, is_d ? d_rsp_error : if_rsp_error}, {31'd0, exp_err});
    @(negedge clk); #1;
    chk({tag, "_t4_pulse_end"}, {30'd0, d_rsp_valid, if_rsp_valid}, 32'd0);
  endtask

  task automatic do_req(input bit is_d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input bit exp_err, input string tag, output int hs_cyc);
    bit got = 1'b0;
    hs_cyc = -1;
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1'b1; d_req_write = wr; d_req_addr = addr; d_req_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (is_d ? d_req_ready : if_req_ready) begin got = 1'b1; hs_cyc = cyc; end
    end
    chk({tag, "_handshake"}, 32'(got), 32'd1);
    if (got) wait_rsp(is_d, exp_data, exp_err, tag);
    else begin if_req_valid = 1'b0; d_req_valid = 1'b0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int c, we0, ifc0, dc0, n, m;
    bit got;
    int hs_c [4]; bit hs_p [4];
    int rs_c [4]; bit rs_p [4]; logic [31:0] rs_d [4];

    if_req_valid = 1'b1; if_req_addr = 32'h0;
    d_req_valid = 1'b0; d_req_write = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0;

    // Reset state, with a fetch already pending.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {25'd0, if_req_ready, if_rsp_valid, if_rsp_error, d_req_ready,
                     d_rsp_valid, d_rsp_error, ram_write_enable}, 32'd0);
    chk("rst_ram_addr", ram_address, 32'd0);
    chk("rst_ram_wval", ram_write_value, 32'd0);
    chk("rst_rsp_data", if_rsp_data | d_rsp_data, 32'd0);

    // First grant only at cycle INIT_CYCLES+1; bytes 0..3 little-endian.
    @(negedge clk); reset = 1'b1;
    got = 1'b0; c = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (if_req_ready) begin got = 1'b1; c = cyc; end
    end
    chk("init_handshake", 32'(got), 32'd1);
    chk("init_first_ready_cyc", 32'(c), 32'd5);
    if (got) wait_rsp(1'b0, 32'h0302_0100, 1'b0, "if_rd0");

    // Data write then fetch of the same word.
    we0 = we_cnt;
    do_req(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, "d_wr100", c);
    chk("d_wr100_one_we", 32'(we_cnt - we0), 32'd1);
    do_req(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, "if_rd100", c);

    // Both ports valid continuously: D, IF, D, IF at 3-cycle spacing.
    @(negedge clk);
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 32'h100;
    if_req_valid = 1'b1; if_req_addr = 32'h4;
    n = 0; m = 0;
    for (int i = 0; i < 40 && m < 4; i++) begin
      #1;
      if (d_req_ready && if_req_ready) chk("rr_both_ready", 32'd1, 32'd0);
      if (n < 4 && (d_req_ready || if_req_ready)) begin
        hs_c[n] = cyc; hs_p[n] = d_req_ready; n++;
      end
      if (m < 4 && (d_rsp_valid || if_rsp_valid)) begin
        rs_c[m] = cyc; rs_p[m] = d_rsp_valid;
        rs_d[m] = d_rsp_valid ? d_rsp_data : if_rsp_data; m++;
      end
      @(negedge clk);
      if (n >= 4) begin d_req_valid = 1'b0; if_req_valid = 1'b0; end
    end
    chk("rr_hs_count", 32'(n), 32'd4);
    chk("rr_rsp_count", 32'(m), 32'd4);
    if (n == 4 && m == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr_port_%0d", k), 32'(hs_p[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("rr_spacing_%0d", k), 32'(hs_c[k] - hs_c[0]), 32'(3 * k));
        chk($sformatf("rr_lat_%0d", k), 32'(rs_c[k] - hs_c[k]), 32'd3);
        chk($sformatf("rr_rsp_port_%0d", k), 32'(rs_p[k]), 32'(hs_p[k]));
        chk($sformatf("rr_data_%0d", k), rs_d[k], hs_p[k] ? 32'hDEAD_BEEF : 32'h0706_0504);
      end

    // Out-of-range write: error, no write enable, contents intact.
    we0 = we_cnt;
    do_req(1'b1, 1'b1, 32'hFFFD, 32'h1234_5678, 32'h0, 1'b1, "d_wr_fffd", c);
    chk("wr_fffd_no_we", 32'(we_cnt - we0), 32'd0);
    do_req(1'b1, 1'b0, 32'hFFFC, 32'h0, 32'hFFFE_FDFC, 1'b0, "d_rd_fffc", c);
    do_req(1'b0, 1'b0, 32'hFFFC, 32'h0, 32'hFFFE_FDFC, 1'b0, "if_rd_fffc", c);
    do_req(1'b0, 1'b0, 32'h1_0000, 32'h0, 32'h0, 1'b1, "if_rd_oor", c);

    // Reset during ACCESS of a write: no commit, no response.
    @(negedge clk);
    d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h200; d_req_wdata = 32'hCAFE_F00D;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (d_req_ready) got = 1'b1;
    end
    chk("mid_handshake", 32'(got), 32'd1);
    @(negedge clk); d_req_valid = 1'b0; #1;
    chk("mid_we_in_access", 32'(ram_write_enable), 32'd1);
    chk("mid_ram_addr", ram_address, 32'h200);
    ifc0 = if_rsp_cnt; dc0 = d_rsp_cnt;
    reset = 1'b0; #1;
    chk("mid_we_cleared", 32'(ram_write_enable), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 32'h0302_0100, 1'b0, "d_rd200_after_rst", c);
    chk("reinit_first_ready_cyc", 32'(c), 32'd5);
    chk("mid_no_extra_d_rsp", 32'(d_rsp_cnt - dc0), 32'd1);
    chk("mid_no_if_rsp", 32'(if_rsp_cnt - ifc0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
